// File: rtl/sd_spi_master.sv
// SPI mode-0 byte master for the SD command path.
// Shifts indexed controller bytes out MSB-first and captures MISO per byte.
module sd_spi_master #(
    parameter int MEMORY_SIZE_IN_BYTES = 64,
    parameter int CLK_DIV = 4,
    localparam int AW = $clog2(MEMORY_SIZE_IN_BYTES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          op,
    input  logic [AW-1:0] size,
    input  logic          ss,
    input  logic [7:0]    data_in,
    output logic [AW-1:0] address,
    output logic [7:0]    data_out,
    output logic          done,
    output logic          busy,
    output logic          rx_valid,
    output logic [AW-1:0] rx_addr,
    output logic [7:0]    rx_data,
    output logic          sd_sclk,
    output logic          sd_mosi,
    input  logic          sd_miso,
    output logic          sd_cs_n
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD   = 3'd1;
    localparam logic [2:0] LOW    = 3'd2;
    localparam logic [2:0] HIGH   = 3'd3;
    localparam logic [2:0] FINISH = 3'd4;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_cnt;
    logic [AW-1:0] size_q;
    logic          op_q;
    logic [7:0]    tx_sr;
    logic [7:0]    rx_sr;
    logic [7:0]    rx_next;
    logic [7:0]    rx_byte;

    // With CLK_DIV=1 the last bit is sampled in the same cycle the byte completes.
    assign rx_next = {rx_sr[6:0], sd_miso};
    assign rx_byte = (cnt == '0) ? rx_next : rx_sr;

    // Idle transmit register holds all ones so MOSI rests high.
    assign sd_mosi = tx_sr[7];
    assign sd_cs_n = ss;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            size_q   <= '0;
            op_q     <= 1'b0;
            tx_sr    <= 8'hFF;
            rx_sr    <= 8'h00;
            address  <= '0;
            data_out <= 8'h00;
            done     <= 1'b0;
            busy     <= 1'b0;
            rx_valid <= 1'b0;
            rx_addr  <= '0;
            rx_data  <= 8'h00;
            sd_sclk  <= 1'b0;
        end else begin
            done     <= 1'b0;
            rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !done) begin
                        size_q  <= size;
                        op_q    <= op;
                        address <= '0;
                        busy    <= 1'b1;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    tx_sr   <= op_q ? data_in : 8'hFF;
                    bit_cnt <= 3'd7;
                    cnt     <= '0;
                    state   <= LOW;
                end
                LOW: begin
                    if (cnt == CNT_MAX) begin
                        cnt     <= '0;
                        sd_sclk <= 1'b1;
                        state   <= HIGH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HIGH: begin
                    if (cnt == '0) begin
                        rx_sr <= rx_next;
                    end
                    if (cnt == CNT_MAX) begin
                        cnt     <= '0;
                        sd_sclk <= 1'b0;
                        if (bit_cnt != 3'd0) begin
                            tx_sr   <= {tx_sr[6:0], 1'b1};
                            bit_cnt <= bit_cnt - 3'd1;
                            state   <= LOW;
                        end else begin
                            data_out <= rx_byte;
                            rx_data  <= rx_byte;
                            rx_addr  <= address;
                            rx_valid <= 1'b1;
                            if (address == size_q) begin
                                state <= FINISH;
                            end else begin
                                address <= address + 1'b1;
                                state   <= LOAD;
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    tx_sr <= 8'hFF;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
